// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: ISA opcodes and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int unsigned OPC_W = 5;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 5'b00000,
        OP_HALT  = 5'b00001,
        OP_LOAD  = 5'b00010,
        OP_STORE = 5'b00011,
        OP_ADD   = 5'b00100,
        OP_SUB   = 5'b00101,
        OP_AND   = 5'b00110,
        OP_OR    = 5'b00111,
        OP_XOR   = 5'b01000,
        OP_JMP   = 5'b01001,
        OP_BEQ   = 5'b01010,
        OP_BNE   = 5'b01011
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pc sequencing with stall/redirect/halt handling and
// a single registered instruction slot presented to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic [INSTR_W-1:0] i_datain,
    output logic [ADDR_W-1:0]  i_addr,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] id_ir,
    output logic               running,
    output logic [15:0]        fetch_count
);

    fetch_state_e       r_state, w_state;
    logic [ADDR_W-1:0]  r_pc, w_pc;
    logic [INSTR_W-1:0] r_ir, w_ir;
    logic [15:0]        r_count, w_count;
    logic               w_is_halt;

    assign w_is_halt = (i_datain[INSTR_W-1 -: OPC_W] == OP_HALT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            r_ir    <= w_ir;
            r_count <= w_count;
        end
    end

    always_comb begin
        w_state = r_state;
        w_pc    = r_pc;
        w_ir    = r_ir;
        w_count = r_count;
        if (enable) begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    w_ir = '0;
                    if (start) begin
                        w_state = ST_RUN;
                        w_pc    = '0;
                        w_count = '0;
                    end
                end
                ST_RUN: begin
                    // Redirect wins over stall; a HALT word is latched but pc stays on it.
                    if (redirect) begin
                        w_pc = redirect_pc;
                        w_ir = '0;
                    end else if (!stall) begin
                        w_ir    = i_datain;
                        w_count = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
                        if (w_is_halt) begin
                            w_state = ST_HALTED;
                        end else begin
                            w_pc = r_pc + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                    w_ir    = '0;
                end
            endcase
        end
    end

    assign i_addr      = r_pc;
    assign id_ir       = r_ir;
    assign running     = (r_state == ST_RUN);
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit, driven from a behavioural
// instruction memory indexed by i_addr.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [15:0] i_datain;
    logic [7:0]  i_addr;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic [15:0] id_ir;
    logic        running;
    logic [15:0] fetch_count;

    logic [15:0] mem [256];
    int passed = 0;
    int total  = 0;

    assign i_datain = mem[i_addr];

    always #5 clock = ~clock;

    fetch_unit #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .i_datain(i_datain), .i_addr(i_addr), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .id_ir(id_ir), .running(running),
        .fetch_count(fetch_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (i_addr !== 8'h00)       $display("FAIL rst_addr got %h exp 00", i_addr); else passed++;
        total++; if (id_ir !== 16'h0000)     $display("FAIL rst_ir got %h exp 0000", id_ir); else passed++;
        total++; if (running !== 1'b0)       $display("FAIL rst_running got %b exp 0", running); else passed++;
        total++; if (fetch_count !== 16'h0)  $display("FAIL rst_count got %h exp 0000", fetch_count); else passed++;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        total++; if (running !== 1'b0 || i_addr !== 8'h00)
            $display("FAIL idle_hold got running=%b addr=%h exp 0/00", running, i_addr); else passed++;
    endtask

    task automatic test_fetch();
        pulse_start();
        total++; if (running !== 1'b1 || i_addr !== 8'h00 || id_ir !== 16'h0000)
            $display("FAIL start got run=%b addr=%h ir=%h exp 1/00/0000", running, i_addr, id_ir); else passed++;
        tick();
        total++; if (i_addr !== 8'h01 || id_ir !== 16'h1011)
            $display("FAIL fetch0 got addr=%h ir=%h exp 01/1011", i_addr, id_ir); else passed++;
        tick();
        total++; if (i_addr !== 8'h02 || id_ir !== 16'h1022)
            $display("FAIL fetch1 got addr=%h ir=%h exp 02/1022", i_addr, id_ir); else passed++;
        tick();
        total++; if (i_addr !== 8'h03 || id_ir !== 16'h0000 || fetch_count !== 16'd3)
            $display("FAIL fetch2 got addr=%h ir=%h cnt=%0d exp 03/0000/3", i_addr, id_ir, fetch_count); else passed++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (i_addr !== 8'h04 || fetch_count !== 16'd4 || id_ir !== 16'h2003)
            $display("FAIL start_in_run got addr=%h cnt=%0d ir=%h exp 04/4/2003", i_addr, fetch_count, id_ir); else passed++;
    endtask

    task automatic test_stall();
        tick();
        total++; if (i_addr !== 8'h05 || id_ir !== 16'h2004)
            $display("FAIL pre_stall got addr=%h ir=%h exp 05/2004", i_addr, id_ir); else passed++;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (i_addr !== 8'h05 || id_ir !== 16'h2004 || fetch_count !== 16'd5)
                $display("FAIL stall%0d got addr=%h ir=%h cnt=%0d exp 05/2004/5", i, i_addr, id_ir, fetch_count); else passed++;
        end
        stall = 1'b0;
        tick();
        total++; if (i_addr !== 8'h06 || id_ir !== 16'h2005 || fetch_count !== 16'd6)
            $display("FAIL stall_release got addr=%h ir=%h cnt=%0d exp 06/2005/6", i_addr, id_ir, fetch_count); else passed++;
    endtask

    task automatic test_redirect();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'h41;
        tick();
        stall = 1'b0;
        redirect = 1'b0;
        total++; if (i_addr !== 8'h41 || id_ir !== 16'h0000 || fetch_count !== 16'd6)
            $display("FAIL redirect got addr=%h ir=%h cnt=%0d exp 41/0000/6", i_addr, id_ir, fetch_count); else passed++;
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 8'hFF;
        tick();
        redirect = 1'b0;
        total++; if (i_addr !== 8'hFF) $display("FAIL wrap_ff got %h exp ff", i_addr); else passed++;
        tick();
        total++; if (i_addr !== 8'h00 || id_ir !== 16'h20FF)
            $display("FAIL wrap_00 got addr=%h ir=%h exp 00/20ff", i_addr, id_ir); else passed++;
        tick();
        total++; if (i_addr !== 8'h01 || id_ir !== 16'h1011 || fetch_count !== 16'd8)
            $display("FAIL wrap_01 got addr=%h ir=%h cnt=%0d exp 01/1011/8", i_addr, id_ir, fetch_count); else passed++;
    endtask

    task automatic test_enable();
        enable = 1'b0;
        start = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'h33;
        repeat (2) tick();
        total++; if (i_addr !== 8'h01 || id_ir !== 16'h1011 || fetch_count !== 16'd8 || running !== 1'b1)
            $display("FAIL enable_hold got addr=%h ir=%h cnt=%0d run=%b exp 01/1011/8/1", i_addr, id_ir, fetch_count, running); else passed++;
        enable = 1'b1;
        start = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic test_async_reset();
        tick();
        total++; if (i_addr !== 8'h02 || id_ir !== 16'h1022)
            $display("FAIL pre_areset got addr=%h ir=%h exp 02/1022", i_addr, id_ir); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (i_addr !== 8'h00 || id_ir !== 16'h0000 || running !== 1'b0 || fetch_count !== 16'd0)
            $display("FAIL areset got addr=%h ir=%h run=%b cnt=%0d exp 00/0000/0/0", i_addr, id_ir, running, fetch_count); else passed++;
        tick();
        reset = 1'b0;
        tick();
        total++; if (running !== 1'b0 || id_ir !== 16'h0000)
            $display("FAIL post_areset got run=%b ir=%h exp 0/0000", running, id_ir); else passed++;
    endtask

    task automatic test_halt();
        mem[4] = 16'h0800;
        pulse_start();
        repeat (4) tick();
        total++; if (i_addr !== 8'h04 || id_ir !== 16'h2003)
            $display("FAIL pre_halt got addr=%h ir=%h exp 04/2003", i_addr, id_ir); else passed++;
        tick();
        total++; if (id_ir !== 16'h0800 || i_addr !== 8'h04 || running !== 1'b0 || fetch_count !== 16'd5)
            $display("FAIL halt got ir=%h addr=%h run=%b cnt=%0d exp 0800/04/0/5", id_ir, i_addr, running, fetch_count); else passed++;
        redirect = 1'b1;
        redirect_pc = 8'h41;
        tick();
        redirect = 1'b0;
        total++; if (id_ir !== 16'h0000 || i_addr !== 8'h04)
            $display("FAIL halted got ir=%h addr=%h exp 0000/04", id_ir, i_addr); else passed++;
        mem[4] = 16'h2004;
        pulse_start();
        total++; if (i_addr !== 8'h00 || running !== 1'b1 || fetch_count !== 16'd0)
            $display("FAIL restart got addr=%h run=%b cnt=%0d exp 00/1/0", i_addr, running, fetch_count); else passed++;
    endtask

    task automatic test_saturate();
        repeat (65535) tick();
        total++; if (fetch_count !== 16'hFFFF)
            $display("FAIL sat_reach got %h exp ffff", fetch_count); else passed++;
        tick();
        total++; if (fetch_count !== 16'hFFFF || running !== 1'b1)
            $display("FAIL sat_hold got cnt=%h run=%b exp ffff/1", fetch_count, running); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h2000 | 16'(i);
        mem[0] = 16'h1011;
        mem[1] = 16'h1022;
        mem[2] = 16'h0000;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_wrap();
        test_enable();
        test_async_reset();
        test_halt();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
